// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and byte constants for the UART command responder
// Contents:
//   state_t      responder FSM states
//   SYNC_BYTE    request frame sync byte
//   RESP_HDR     response frame header byte
//   CMD_*        request command codes
//   STAT_*       response status codes
//   frame_chk()  XOR checksum over CMD, ADDR, DATA
package uart_pkg;

  typedef enum logic [3:0] {
    HUNT,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    EXEC,
    TX_HDR,
    TX_STAT,
    TX_DATA
  } state_t;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] RESP_HDR      = 8'h5A;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ      = 8'h02;

  localparam logic [7:0] STAT_OK       = 8'h00;
  localparam logic [7:0] STAT_BAD_CHK  = 8'h01;
  localparam logic [7:0] STAT_BAD_CMD  = 8'h02;
  localparam logic [7:0] STAT_BAD_ADDR = 8'h03;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// rtl/uart_byte_timeout.sv - inter-byte gap timer for frame reception
// Ports:
//   clk      clock
//   reset    synchronous active-high reset
//   restart  a byte was accepted; gap count starts again from zero
//   enable   a frame is being collected; when low the timer is held cleared
//   expired  TIMEOUT_CYCLES cycles have passed since the last restart
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // count holds (cycles since restart - 1), so it reaches LAST on the
  // TIMEOUT_CYCLES-th idle cycle; it parks there rather than wrapping.
  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable || restart) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - register-file command responder behind a byte UART
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   i_Rx_Done    one-cycle pulse, i_Rx_Byte valid
//   i_Rx_Byte    received byte
//   o_Tx_Byte    byte to transmit, stable while o_Tx_Ready is high
//   o_Tx_Ready   level request to transmit o_Tx_Byte
//   i_Tx_Done    one-cycle pulse, requested byte has been sent
//   o_Wr_Strobe  one-cycle pulse, register write
//   o_Wr_Addr    address of that write
//   o_Wr_Data    data of that write
//   o_Rx_Drop    one-cycle pulse, a byte was discarded while busy responding
// Request frame: A5 CMD ADDR DATA CHK; response: 5A STATUS DATA.
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NUM_REGS       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Rx_Done,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Tx_Ready,
  input  logic       i_Tx_Done,
  output logic       o_Wr_Strobe,
  output logic [3:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Rx_Drop
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_t     state;
  logic [7:0] cmd_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] chk_q;
  logic [7:0] status_q;
  logic [7:0] resp_data_q;
  logic [7:0] regs [16];

  logic       in_get;
  logic       in_busy;
  logic       expired;
  logic [7:0] exec_status;
  logic       exec_write;
  logic [7:0] tx_byte;
  state_t     tx_next;

  assign in_get  = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
  assign in_busy = state inside {EXEC, TX_HDR, TX_STAT, TX_DATA};

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .restart(i_Rx_Done),
    .enable (in_get),
    .expired(expired)
  );

  // Status priority: checksum, then command, then address.
  always_comb begin
    exec_status = STAT_OK;
    if (chk_q != frame_chk(cmd_q, addr_q, data_q)) begin
      exec_status = STAT_BAD_CHK;
    end else if (cmd_q != CMD_WRITE && cmd_q != CMD_READ) begin
      exec_status = STAT_BAD_CMD;
    end else if (addr_q >= NUM_REGS_B) begin
      exec_status = STAT_BAD_ADDR;
    end
  end

  assign exec_write = (exec_status == STAT_OK) && (cmd_q == CMD_WRITE);

  // Byte presented and successor state for each response phase.
  always_comb begin
    tx_byte = RESP_HDR;
    tx_next = TX_STAT;
    case (state)
      TX_STAT: begin
        tx_byte = status_q;
        tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_byte = resp_data_q;
        tx_next = HUNT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      chk_q       <= 8'h00;
      status_q    <= 8'h00;
      resp_data_q <= 8'h00;
      o_Tx_Byte   <= 8'h00;
      o_Tx_Ready  <= 1'b0;
      o_Wr_Strobe <= 1'b0;
      o_Wr_Addr   <= 4'h0;
      o_Wr_Data   <= 8'h00;
      o_Rx_Drop   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      o_Wr_Strobe <= 1'b0;
      o_Rx_Drop   <= i_Rx_Done && in_busy;

      case (state)
        HUNT: begin
          if (i_Rx_Done && i_Rx_Byte == SYNC_BYTE) begin
            state <= GET_CMD;
          end
        end

        // A byte on the expiry cycle wins over the timeout.
        GET_CMD: begin
          if (i_Rx_Done) begin
            cmd_q <= i_Rx_Byte;
            state <= GET_ADDR;
          end else if (expired) begin
            state <= HUNT;
          end
        end

        GET_ADDR: begin
          if (i_Rx_Done) begin
            addr_q <= i_Rx_Byte;
            state  <= GET_DATA;
          end else if (expired) begin
            state <= HUNT;
          end
        end

        GET_DATA: begin
          if (i_Rx_Done) begin
            data_q <= i_Rx_Byte;
            state  <= GET_CHK;
          end else if (expired) begin
            state <= HUNT;
          end
        end

        GET_CHK: begin
          if (i_Rx_Done) begin
            chk_q <= i_Rx_Byte;
            state <= EXEC;
          end else if (expired) begin
            state <= HUNT;
          end
        end

        // A write echoes the value it stores, so the response uses data_q
        // directly instead of reading back the register being written.
        EXEC: begin
          status_q <= exec_status;
          if (exec_write) begin
            regs[addr_q[3:0]] <= data_q;
            o_Wr_Strobe       <= 1'b1;
            o_Wr_Addr         <= addr_q[3:0];
            o_Wr_Data         <= data_q;
            resp_data_q       <= data_q;
          end else if (exec_status == STAT_OK) begin
            resp_data_q <= regs[addr_q[3:0]];
          end else begin
            resp_data_q <= 8'h00;
          end
          state <= TX_HDR;
        end

        // Each phase enters with o_Tx_Ready low, raises it for one byte and
        // drops it on i_Tx_Done, which guarantees a low cycle between bytes.
        TX_HDR, TX_STAT, TX_DATA: begin
          if (!o_Tx_Ready) begin
            o_Tx_Ready <= 1'b1;
            o_Tx_Byte  <= tx_byte;
          end else if (i_Tx_Done) begin
            o_Tx_Ready <= 1'b0;
            state      <= tx_next;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - self-checking bench for uart_cmd_responder
module tb_uart_cmd_responder;

  localparam int T  = 64;
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_Rx_Done;
  logic [7:0] i_Rx_Byte;
  logic [7:0] o_Tx_Byte;
  logic       o_Tx_Ready;
  logic       i_Tx_Done;
  logic       o_Wr_Strobe;
  logic [3:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Rx_Drop;

  uart_cmd_responder #(
    .TIMEOUT_CYCLES(T),
    .NUM_REGS      (NR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Rx_Done  (i_Rx_Done),
    .i_Rx_Byte  (i_Rx_Byte),
    .o_Tx_Byte  (o_Tx_Byte),
    .o_Tx_Ready (o_Tx_Ready),
    .i_Tx_Done  (i_Tx_Done),
    .o_Wr_Strobe(o_Wr_Strobe),
    .o_Wr_Addr  (o_Wr_Addr),
    .o_Wr_Data  (o_Wr_Data),
    .o_Rx_Drop  (o_Rx_Drop)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl_regs [16];
  logic [7:0]  tx_q [$];
  logic [11:0] wr_q [$];
  int          drop_cnt = 0;
  bit          spurious_req = 1'b0;
  int          tx_delay = 0;
  bit          prev_ready = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  // Output monitor: writes, drops, byte stability while requested.
  initial begin
    forever begin
      @(negedge clk);
      if (o_Wr_Strobe === 1'b1) wr_q.push_back({o_Wr_Addr, o_Wr_Data});
      if (o_Rx_Drop === 1'b1) drop_cnt++;
      if (prev_ready && o_Tx_Ready === 1'b1) begin
        checks++;
        if (o_Tx_Byte !== prev_byte) begin
          errors++;
          $display("FAIL tx_stable byte=%h required %h", o_Tx_Byte, prev_byte);
        end
      end
      prev_ready = (o_Tx_Ready === 1'b1);
      prev_byte  = o_Tx_Byte;
    end
  end

  // Transmitter model: random latency, one-cycle done pulse.
  initial begin
    i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (i_Tx_Done) begin
        i_Tx_Done = 1'b0;
        checks++;
        if (o_Tx_Ready !== 1'b0) begin
          errors++;
          $display("FAIL tx_gap ready=%b required 0", o_Tx_Ready);
        end
        tx_delay = $urandom_range(0, 3);
      end else if (o_Tx_Ready === 1'b1) begin
        if (tx_delay == 0) begin
          tx_q.push_back(o_Tx_Byte);
          i_Tx_Done = 1'b1;
        end else begin
          tx_delay--;
        end
      end else if (spurious_req) begin
        spurious_req = 1'b0;
        i_Tx_Done    = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] chk,
                             output logic [7:0] st, output logic [7:0] d,
                             output bit wr);
    if ((cmd ^ addr ^ data) != chk) st = 8'h01;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
    else if (int'(addr) >= NR) st = 8'h03;
    else st = 8'h00;
    wr = (st == 8'h00) && (cmd == 8'h01);
    if (wr) mdl_regs[addr[3:0]] = data;
    d = (st == 8'h00) ? mdl_regs[addr[3:0]] : 8'h00;
  endtask

  // idle = number of clock edges with i_Rx_Done low before this byte.
  task automatic send_byte(input logic [7:0] b, input int idle);
    repeat (idle) @(negedge clk);
    i_Rx_Byte = b;
    i_Rx_Done = 1'b1;
    @(negedge clk);
    i_Rx_Done = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [7:0] st, input logic [7:0] d);
    int cyc = 0;
    while (tx_q.size() < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (tx_q.size() != 3) begin
      errors++;
      $display("FAIL %s resp_count got %0d required 3", name, tx_q.size());
    end else begin
      checks++;
      if ({tx_q[0], tx_q[1], tx_q[2]} !== {8'h5A, st, d}) begin
        errors++;
        $display("FAIL %s resp got %h %h %h required 5a %h %h", name,
                 tx_q[0], tx_q[1], tx_q[2], st, d);
      end
    end
    tx_q.delete();
  endtask

  task automatic expect_none(input string name, input int cycles);
    repeat (cycles) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s unexpected_tx got %0d bytes required 0", name, tx_q.size());
    end
    tx_q.delete();
  endtask

  task automatic check_writes(input string name, input bit wr,
                              input logic [7:0] addr, input logic [7:0] data);
    checks++;
    if (wr_q.size() != (wr ? 1 : 0)) begin
      errors++;
      $display("FAIL %s wr_count got %0d required %0d", name, wr_q.size(), wr ? 1 : 0);
    end else if (wr) begin
      checks++;
      if (wr_q[0] !== {addr[3:0], data}) begin
        errors++;
        $display("FAIL %s wr got %h required %h", name, wr_q[0], {addr[3:0], data});
      end
    end
    wr_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk, input int max_gap);
    send_byte(8'hA5, $urandom_range(1, max_gap));
    send_byte(cmd,   $urandom_range(1, max_gap));
    send_byte(addr,  $urandom_range(1, max_gap));
    send_byte(data,  $urandom_range(1, max_gap));
    send_byte(chk,   $urandom_range(1, max_gap));
  endtask

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] chk);
    logic [7:0] st, d;
    bit wr;
    send_frame(cmd, addr, data, chk, 6);
    model_frame(cmd, addr, data, chk, st, d, wr);
    expect_resp(name, st, d);
    check_writes(name, wr, addr, data);
  endtask

  task automatic wait_ready(input string name, input logic lvl);
    int cyc = 0;
    while (o_Tx_Ready !== lvl && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (o_Tx_Ready !== lvl) begin
      errors++;
      $display("FAIL %s wait_ready got %b required %b", name, o_Tx_Ready, lvl);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    i_Rx_Done = 1'b0;
    i_Rx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_Tx_Ready, o_Wr_Strobe, o_Rx_Drop} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000", {o_Tx_Ready, o_Wr_Strobe, o_Rx_Drop});
    end
    checks++;
    if ({o_Tx_Byte, o_Wr_Addr, o_Wr_Data} !== 20'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 00000", {o_Tx_Byte, o_Wr_Addr, o_Wr_Data});
    end
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    run_frame("reset_read", 8'h02, 8'h07, 8'h00, 8'h05);
  endtask

  task automatic test_directed();
    run_frame("write",     8'h01, 8'h03, 8'h5C, 8'h5E);
    run_frame("read",      8'h02, 8'h03, 8'h00, 8'h01);
    run_frame("bad_chk",   8'h01, 8'h03, 8'h5C, 8'h00);
    run_frame("reread",    8'h02, 8'h03, 8'h00, 8'h01);
    run_frame("bad_addr",  8'h02, 8'h1F, 8'h00, 8'h1D);
    run_frame("bad_cmd",   8'h07, 8'h00, 8'h00, 8'h07);
    run_frame("last_addr", 8'h01, 8'h0F, 8'h3C, 8'h01 ^ 8'h0F ^ 8'h3C);
    run_frame("addr_nr",   8'h02, 8'h10, 8'h00, 8'h12);
    run_frame("a5_data",   8'h01, 8'h05, 8'hA5, 8'h01 ^ 8'h05 ^ 8'hA5);
    run_frame("a5_addr",   8'h02, 8'hA5, 8'h00, 8'h02 ^ 8'hA5);
  endtask

  task automatic test_timeout();
    // Stale partial frame, gap of T, then a complete frame: one response.
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'hA5, T);
    send_byte(8'h02, 2);
    send_byte(8'h03, 2);
    send_byte(8'h00, 2);
    send_byte(8'h01, 2);
    expect_resp("timeout_resync", 8'h00, 8'h5C);
    expect_none("timeout_single", 40);
    check_writes("timeout_nowr", 1'b0, 8'h00, 8'h00);
    // Every byte lands exactly on the expiry cycle and must be accepted.
    send_byte(8'hA5, 2);
    send_byte(8'h01, T - 1);
    send_byte(8'h0A, T - 1);
    send_byte(8'h33, T - 1);
    send_byte(8'h01 ^ 8'h0A ^ 8'h33, T - 1);
    mdl_regs[10] = 8'h33;
    expect_resp("timeout_edge", 8'h00, 8'h33);
    check_writes("timeout_edge", 1'b1, 8'h0A, 8'h33);
    // Timed-out frame whose tail arrives in HUNT produces nothing.
    send_byte(8'hA5, 2);
    send_byte(8'h02, 2);
    send_byte(8'h03, T);
    send_byte(8'h00, 2);
    send_byte(8'h01, 2);
    expect_none("timeout_drop", 60);
  endtask

  task automatic test_overrun();
    logic [7:0] st, d;
    bit wr;
    drop_cnt = 0;
    send_frame(8'h01, 8'h08, 8'h77, 8'h01 ^ 8'h08 ^ 8'h77, 4);
    model_frame(8'h01, 8'h08, 8'h77, 8'h01 ^ 8'h08 ^ 8'h77, st, d, wr);
    wait_ready("ovr_hdr", 1'b1);
    checks++;
    if (o_Tx_Byte !== 8'h5A) begin
      errors++;
      $display("FAIL ovr_hdr_byte got %h required 5a", o_Tx_Byte);
    end
    wait_ready("ovr_gap", 1'b0);
    wait_ready("ovr_stat", 1'b1);
    send_byte(8'($urandom), 0);
    expect_resp("overrun", st, d);
    check_writes("overrun", wr, 8'h08, 8'h77);
    checks++;
    if (drop_cnt != 1) begin
      errors++;
      $display("FAIL overrun_drop got %0d required 1", drop_cnt);
    end
  endtask

  task automatic test_spurious_tx_done();
    spurious_req = 1'b1;
    repeat (5) @(negedge clk);
    expect_none("spurious", 5);
    run_frame("after_spurious", 8'h02, 8'h08, 8'h00, 8'h0A);
  endtask

  task automatic test_reset_mid();
    send_frame(8'h01, 8'h09, 8'h44, 8'h01 ^ 8'h09 ^ 8'h44, 4);
    wait_ready("rst_hdr", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_Tx_Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_ready got %b required 0", o_Tx_Ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    tx_q.delete();
    wr_q.delete();
    expect_none("reset_abort", 40);
    // Reset mid-frame: the tail of the frame is junk in HUNT.
    send_byte(8'hA5, 2);
    send_byte(8'h02, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h03, 2);
    send_byte(8'h00, 2);
    send_byte(8'h01, 2);
    expect_none("reset_midframe", 40);
    run_frame("reset_cleared", 8'h02, 8'h03, 8'h00, 8'h01);
  endtask

  task automatic test_random();
    drop_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] cmd, addr, data, chk, g;
      int r, ng;
      ng = $urandom_range(0, 3);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(1, 10));
      end
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h01;
      else if (r < 8) cmd = 8'h02;
      else cmd = 8'($urandom);
      addr = 8'($urandom_range(0, 19));
      data = 8'($urandom);
      chk  = cmd ^ addr ^ data;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_frame("random", cmd, addr, data, chk);
    end
    checks++;
    if (drop_cnt != 0) begin
      errors++;
      $display("FAIL random_drop got %0d required 0", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_overrun();
    test_spurious_tx_done();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
